// File: rtl/io_response_collector_pkg.sv
// ----------------------------------------------------------------------------
// io_bus_pkg
// Shared IO-bus definitions used by the IO response path.
//   IO_DATA_W        : IO data bus width (16 bits)
//   IO_FLOAT_DATA    : value read from a floating (undriven) IO bus
//   io_resp_state_t  : response collector FSM states
// ----------------------------------------------------------------------------
package io_bus_pkg;

    localparam int unsigned IO_DATA_W = 16;

    localparam logic [IO_DATA_W-1:0] IO_FLOAT_DATA = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_GAP
    } io_resp_state_t;

endpackage

// File: rtl/io_response_collector_if.sv
// ----------------------------------------------------------------------------
// io_response_collector_if
// Bundles the CPU data-master IO handshake, the decoder selects and the
// peripheral return path.
//   d_io, data_m_access, data_m_wr_en : CPU request side
//   sel, default_sel                  : decoder selects
//   slv_ack, slv_data                 : per-peripheral ack and packed read data
//   data_m_ack, data_m_data_in        : response back to the CPU
// Modports:
//   slave  : the response collector
//   master : the CPU/decoder/peripheral side driving requests
// ----------------------------------------------------------------------------
interface io_response_collector_if
    import io_bus_pkg::*;
#(
    parameter int unsigned N_SLAVES = 16
);

    logic                          d_io;
    logic                          data_m_access;
    logic                          data_m_wr_en;
    logic [N_SLAVES-1:0]           sel;
    logic                          default_sel;
    logic [N_SLAVES-1:0]           slv_ack;
    logic [N_SLAVES*IO_DATA_W-1:0] slv_data;
    logic                          data_m_ack;
    logic [IO_DATA_W-1:0]          data_m_data_in;

    modport slave (
        input  d_io, data_m_access, data_m_wr_en, sel, default_sel,
               slv_ack, slv_data,
        output data_m_ack, data_m_data_in
    );

    modport master (
        output d_io, data_m_access, data_m_wr_en, sel, default_sel,
               slv_ack, slv_data,
        input  data_m_ack, data_m_data_in
    );

endinterface

// File: rtl/io_response_collector_mux.sv
// ----------------------------------------------------------------------------
// io_onehot_mux
// N x W AND-OR data mux plus zero / one-hot / multi-hot classification of
// the select vector.
//   sel_i    : select vector (expected one-hot for a clean mux result)
//   data_i   : packed data, entry i at [W*i +: W]
//   data_o   : OR of all selected entries
//   zero_o   : no select bit set
//   onehot_o : exactly one select bit set
//   multi_o  : two or more select bits set
// ----------------------------------------------------------------------------
module io_onehot_mux
    import io_bus_pkg::*;
#(
    parameter int unsigned N = 16,
    parameter int unsigned W = IO_DATA_W
) (
    input  logic [N-1:0]   sel_i,
    input  logic [N*W-1:0] data_i,
    output logic [W-1:0]   data_o,
    output logic           zero_o,
    output logic           onehot_o,
    output logic           multi_o
);

    always_comb begin
        data_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            data_o = data_o | (data_i[i*W +: W] & {W{sel_i[i]}});
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign zero_o   = (sel_i == '0);
    assign multi_o  = |(sel_i & (sel_i - N'(1)));
    assign onehot_o = !zero_o && !multi_o;

endmodule

// File: rtl/io_response_collector.sv
// ----------------------------------------------------------------------------
// io_response_collector
// Terminates every IO cycle of the CPU data master exactly once: waits for
// the selected peripheral's ack and returns its data, or completes with
// floating-bus data for unmapped, conflicting-select or timed-out accesses.
//   clk, reset_n     : clock, asynchronous active-low reset
//   bus (slave)      : CPU handshake, decoder selects, peripheral return path
//   timeout_pulse    : one-cycle pulse with the ack of a timed-out access
//   sel_error_pulse  : one-cycle pulse with the ack of a multi-hot access
// data_m_wr_en is part of the bus but does not affect the response; write
// cycles are answered exactly like reads.
// ----------------------------------------------------------------------------
module io_response_collector
    import io_bus_pkg::*;
#(
    parameter int unsigned          N_SLAVES       = 16,
    parameter int unsigned          TIMEOUT_CYCLES = 255,
    parameter logic [IO_DATA_W-1:0] FLOAT_DATA     = IO_FLOAT_DATA
) (
    input  logic                     clk,
    input  logic                     reset_n,
    io_response_collector_if.slave   bus,
    output logic                     timeout_pulse,
    output logic                     sel_error_pulse
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    io_resp_state_t       state_q, state_d;
    logic [N_SLAVES-1:0]  sel_q, sel_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 ack_q, ack_d;
    logic [IO_DATA_W-1:0] data_q, data_d;
    logic                 tout_q, tout_d;
    logic                 serr_q, serr_d;

    logic [N_SLAVES-1:0]  mux_sel;
    logic [IO_DATA_W-1:0] mux_data;
    logic                 mux_zero, mux_onehot, mux_multi;
    logic                 accept, float_resp, hit, expired;

    // One mux serves both phases: in IDLE it classifies the decoder selects,
    // in WAIT it sees only the latched slave's ack, so a nonzero result is a hit.
    assign mux_sel = (state_q == ST_IDLE) ? bus.sel : (bus.slv_ack & sel_q);

    io_onehot_mux #(
        .N (N_SLAVES),
        .W (IO_DATA_W)
    ) u_mux (
        .sel_i    (mux_sel),
        .data_i   (bus.slv_data),
        .data_o   (mux_data),
        .zero_o   (mux_zero),
        .onehot_o (mux_onehot),
        .multi_o  (mux_multi)
    );

    assign accept     = bus.d_io && bus.data_m_access;
    assign float_resp = bus.default_sel || !mux_onehot;
    assign hit        = !mux_zero;
    assign expired    = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = float_resp ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (hit) begin
                    state_d = ST_RESP;
                end else if (!bus.data_m_access) begin
                    state_d = ST_IDLE;
                end else if (expired) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values; response registers are loaded on the
    // transition into RESP so they are high exactly during RESP.
    always_comb begin
        sel_d  = sel_q;
        cnt_d  = cnt_q;
        ack_d  = 1'b0;
        data_d = '0;
        tout_d = 1'b0;
        serr_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (float_resp) begin
                        ack_d  = 1'b1;
                        data_d = FLOAT_DATA;
                        serr_d = !bus.default_sel && mux_multi;
                    end else begin
                        sel_d = bus.sel;
                        cnt_d = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (hit) begin
                    ack_d  = 1'b1;
                    data_d = mux_data;
                end else if (!bus.data_m_access) begin
                    cnt_d = cnt_q;
                end else if (expired) begin
                    ack_d  = 1'b1;
                    data_d = FLOAT_DATA;
                    tout_d = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                ack_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q  <= '0;
            cnt_q  <= '0;
            ack_q  <= 1'b0;
            data_q <= '0;
            tout_q <= 1'b0;
            serr_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            cnt_q  <= cnt_d;
            ack_q  <= ack_d;
            data_q <= data_d;
            tout_q <= tout_d;
            serr_q <= serr_d;
        end
    end

    assign bus.data_m_ack     = ack_q;
    assign bus.data_m_data_in = data_q;
    assign timeout_pulse      = tout_q;
    assign sel_error_pulse    = serr_q;

endmodule
